// File: rtl/semaforo_pkg.sv
// Shared types and helpers for the traffic-light monitor: lamp decode,
// monitor states, fault codes and the legal phase order.
package semaforo_pkg;

    typedef enum logic [2:0] {
        LAMP_OFF    = 3'd0,
        LAMP_RED    = 3'd1,
        LAMP_YELLOW = 3'd2,
        LAMP_GREEN  = 3'd3,
        LAMP_MULTI  = 3'd4
    } lamp_e;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_SYNC  = 2'd1,
        ST_TRACK = 2'd2,
        ST_MAINT = 2'd3
    } mon_state_e;

    typedef enum logic [2:0] {
        F_NONE        = 3'd0,
        F_MULTI       = 3'd1,
        F_DARK        = 3'd2,
        F_ILLEGAL_SEQ = 3'd3,
        F_SHORT       = 3'd4,
        F_LONG        = 3'd5
    } fault_e;

    function automatic lamp_e decode_lamp(input logic r, input logic y, input logic g);
        lamp_e l;
        case ({r, y, g})
            3'b000:  l = LAMP_OFF;
            3'b100:  l = LAMP_RED;
            3'b010:  l = LAMP_YELLOW;
            3'b001:  l = LAMP_GREEN;
            default: l = LAMP_MULTI;
        endcase
        return l;
    endfunction

    function automatic logic is_single(input lamp_e l);
        return (l == LAMP_RED) || (l == LAMP_YELLOW) || (l == LAMP_GREEN);
    endfunction

    // Only meaningful for a single lit lamp; anything else has no successor.
    function automatic lamp_e next_legal(input lamp_e l);
        lamp_e n;
        case (l)
            LAMP_RED:    n = LAMP_GREEN;
            LAMP_GREEN:  n = LAMP_YELLOW;
            LAMP_YELLOW: n = LAMP_RED;
            default:     n = LAMP_OFF;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/semaforo_phase_timer.sv
// Phase length counter with load/saturate and the SHORT/LONG comparisons
// of the running count against the programmed duration of the current lamp.
module semaforo_phase_timer #(
    parameter int WIDTH = 32,
    parameter int TOL   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] dur_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             short_o,
    output logic             long_o
);

    localparam logic [WIDTH:0] TOL_W = (WIDTH+1)'(TOL);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             long_done_q, long_done_d;
    logic [WIDTH:0]   cnt_ext, dur_ext, lo_bound, hi_bound;
    logic             over;

    // Bounds are one bit wider so dur+TOL cannot wrap and dur-TOL clamps at zero.
    always_comb begin
        cnt_ext     = {1'b0, cnt_q};
        dur_ext     = {1'b0, dur_i};
        lo_bound    = (dur_ext > TOL_W) ? (dur_ext - TOL_W) : '0;
        hi_bound    = dur_ext + TOL_W;
        over        = (dur_i != '0) && (cnt_ext > hi_bound);
        short_o     = (dur_i != '0) && (cnt_ext < lo_bound);
        long_o      = over && !long_done_q;
        cnt_d       = cnt_q;
        long_done_d = long_done_q;
        if (clear_i) begin
            cnt_d       = '0;
            long_done_d = 1'b0;
        end else if (load_i) begin
            cnt_d       = WIDTH'(1);
            long_done_d = 1'b0;
        end else begin
            if (cnt_q != '1) cnt_d = cnt_q + WIDTH'(1);
            if (over) long_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            long_done_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            long_done_q <= long_done_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/semaforo_monitor.sv
// Downstream checker for the traffic-light controller: lamp legality, phase
// order and dwell time, with sticky fault reporting and cycle statistics.
module semaforo_monitor
    import semaforo_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int TOL    = 1,
    parameter int FCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              maintenance,
    input  logic              red,
    input  logic              yellow,
    input  logic              green,
    input  logic [WIDTH-1:0]  red_duration,
    input  logic [WIDTH-1:0]  yellow_duration,
    input  logic [WIDTH-1:0]  green_duration,
    input  logic              clear_fault,
    output logic              fault,
    output logic [2:0]        fault_code,
    output logic [FCNT_W-1:0] fault_count,
    output logic [WIDTH-1:0]  cycle_count,
    output logic [WIDTH-1:0]  phase_len,
    output logic              phase_valid
);

    lamp_e             lamp, prev_lamp_q;
    mon_state_e        state_q, state_d;
    fault_e            ev_code;
    logic              checks_on, tracking, changed, prev_lit, cur_lit, lit_to_lit, legal;
    logic [WIDTH-1:0]  dur_sel, cnt;
    logic              t_short, t_long, t_clear;

    logic              fault_q, fault_d;
    logic [2:0]        fault_code_q, fault_code_d;
    logic [FCNT_W-1:0] fault_count_q, fault_count_d;
    logic [WIDTH-1:0]  cycle_count_q, cycle_count_d;
    logic [WIDTH-1:0]  phase_len_q, phase_len_d;
    logic              phase_valid_q, phase_valid_d;

    // The duration that matters is always that of the lamp registered last
    // cycle: it is the phase that is either still running or just ended.
    always_comb begin
        lamp       = decode_lamp(red, yellow, green);
        checks_on  = !maintenance && (state_q != ST_MAINT);
        tracking   = (state_q == ST_SYNC) || (state_q == ST_TRACK);
        changed    = (lamp != prev_lamp_q);
        prev_lit   = is_single(prev_lamp_q);
        cur_lit    = is_single(lamp);
        lit_to_lit = changed && prev_lit && cur_lit;
        legal      = (lamp == next_legal(prev_lamp_q));
        t_clear    = maintenance || (state_q == ST_MAINT);
        case (prev_lamp_q)
            LAMP_RED:    dur_sel = red_duration;
            LAMP_YELLOW: dur_sel = yellow_duration;
            LAMP_GREEN:  dur_sel = green_duration;
            default:     dur_sel = '0;
        endcase
    end

    semaforo_phase_timer #(
        .WIDTH (WIDTH),
        .TOL   (TOL)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (t_clear),
        .load_i  (changed),
        .dur_i   (dur_sel),
        .cnt_o   (cnt),
        .short_o (t_short),
        .long_o  (t_long)
    );

    always_comb begin
        ev_code = F_NONE;
        if (checks_on) begin
            if (lamp == LAMP_MULTI)                                 ev_code = F_MULTI;
            else if (tracking && prev_lit && lamp == LAMP_OFF)      ev_code = F_DARK;
            else if (tracking && lit_to_lit && !legal)              ev_code = F_ILLEGAL_SEQ;
            else if (state_q == ST_TRACK && lit_to_lit && t_short)  ev_code = F_SHORT;
            else if (state_q == ST_TRACK && prev_lit && !changed && t_long)
                                                                    ev_code = F_LONG;
        end
    end

    // A MULTI sample loses track of where the phase began, so fall back to SYNC.
    always_comb begin
        state_d = state_q;
        if (maintenance) begin
            state_d = ST_MAINT;
        end else begin
            case (state_q)
                ST_OFF:   if (cur_lit) state_d = ST_SYNC;
                ST_SYNC: begin
                    if (lamp == LAMP_OFF)           state_d = ST_OFF;
                    else if (lit_to_lit && legal)   state_d = ST_TRACK;
                end
                ST_TRACK: begin
                    if (lamp == LAMP_OFF)           state_d = ST_OFF;
                    else if (lamp == LAMP_MULTI)    state_d = ST_SYNC;
                    else if (lit_to_lit && !legal)  state_d = ST_SYNC;
                end
                ST_MAINT: state_d = (lamp == LAMP_OFF) ? ST_OFF : ST_SYNC;
                default:  state_d = ST_OFF;
            endcase
        end
    end

    always_comb begin
        fault_d       = fault_q;
        fault_code_d  = fault_code_q;
        fault_count_d = fault_count_q;
        cycle_count_d = cycle_count_q;
        phase_len_d   = phase_len_q;
        phase_valid_d = 1'b0;
        if (ev_code != F_NONE) begin
            fault_d = 1'b1;
            if (!fault_q || clear_fault) fault_code_d = ev_code;
            if (fault_count_q != '1) fault_count_d = fault_count_q + FCNT_W'(1);
        end else if (clear_fault) begin
            fault_d      = 1'b0;
            fault_code_d = F_NONE;
        end
        if (checks_on && tracking && lit_to_lit) begin
            phase_len_d   = cnt;
            phase_valid_d = 1'b1;
        end
        if (checks_on && state_q == ST_TRACK && prev_lamp_q == LAMP_YELLOW &&
            lamp == LAMP_RED && ev_code == F_NONE)
            cycle_count_d = cycle_count_q + WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_OFF;
            prev_lamp_q   <= LAMP_OFF;
            fault_q       <= 1'b0;
            fault_code_q  <= '0;
            fault_count_q <= '0;
            cycle_count_q <= '0;
            phase_len_q   <= '0;
            phase_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_lamp_q   <= lamp;
            fault_q       <= fault_d;
            fault_code_q  <= fault_code_d;
            fault_count_q <= fault_count_d;
            cycle_count_q <= cycle_count_d;
            phase_len_q   <= phase_len_d;
            phase_valid_q <= phase_valid_d;
        end
    end

    assign fault       = fault_q;
    assign fault_code  = fault_code_q;
    assign fault_count = fault_count_q;
    assign cycle_count = cycle_count_q;
    assign phase_len   = phase_len_q;
    assign phase_valid = phase_valid_q;

endmodule

// File: tb/tb_semaforo_monitor.sv
// Bench for semaforo_monitor: directed scenarios plus a randomized lamp
// sequence checked against a cycle-level reference model of the monitor rules.
module tb_semaforo_monitor;

    localparam int WIDTH  = 32;
    localparam int TOL    = 1;
    localparam int FCNT_W = 8;
    localparam longint CNT_MAX = (64'd1 << WIDTH) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              maintenance = 1'b0;
    logic              red = 1'b0, yellow = 1'b0, green = 1'b0;
    logic              clear_fault = 1'b0;
    logic [WIDTH-1:0]  red_duration = 32'd10;
    logic [WIDTH-1:0]  yellow_duration = 32'd3;
    logic [WIDTH-1:0]  green_duration = 32'd7;
    logic              fault;
    logic [2:0]        fault_code;
    logic [FCNT_W-1:0] fault_count;
    logic [WIDTH-1:0]  cycle_count;
    logic [WIDTH-1:0]  phase_len;
    logic              phase_valid;

    int checks = 0;
    int passed = 0;

    // Reference model state; lamps are characters O R Y G M.
    byte    mPrev;
    byte    mMode;
    longint mCnt;
    bit     mLongDone;
    bit     mFault;
    int     mCode;
    int     mFcount;
    longint mCycles;
    longint mPhaseLen;
    bit     mPhaseValid;

    semaforo_monitor #(.WIDTH(WIDTH), .TOL(TOL), .FCNT_W(FCNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .maintenance     (maintenance),
        .red             (red),
        .yellow          (yellow),
        .green           (green),
        .red_duration    (red_duration),
        .yellow_duration (yellow_duration),
        .green_duration  (green_duration),
        .clear_fault     (clear_fault),
        .fault           (fault),
        .fault_code      (fault_code),
        .fault_count     (fault_count),
        .cycle_count     (cycle_count),
        .phase_len       (phase_len),
        .phase_valid     (phase_valid)
    );

    always #5 clk = ~clk;

    function automatic byte lampOf(input logic r, input logic y, input logic g);
        int n;
        n = int'(r) + int'(y) + int'(g);
        if (n == 0) return "O";
        if (n > 1)  return "M";
        if (r) return "R";
        if (y) return "Y";
        return "G";
    endfunction

    function automatic bit isLit(input byte l);
        return (l == "R") || (l == "G") || (l == "Y");
    endfunction

    // Position in the cyclic order red, green, yellow.
    function automatic int ordPos(input byte l);
        case (l)
            "R":     return 0;
            "G":     return 1;
            "Y":     return 2;
            default: return -9;
        endcase
    endfunction

    function automatic byte lampAt(input int p);
        case (p % 3)
            0:       return "R";
            1:       return "G";
            default: return "Y";
        endcase
    endfunction

    function automatic longint durOf(input byte l);
        case (l)
            "R":     return longint'(red_duration);
            "Y":     return longint'(yellow_duration);
            "G":     return longint'(green_duration);
            default: return 0;
        endcase
    endfunction

    task automatic modelReset();
        mPrev = "O"; mMode = "o"; mCnt = 0; mLongDone = 0;
        mFault = 0; mCode = 0; mFcount = 0; mCycles = 0;
        mPhaseLen = 0; mPhaseValid = 0;
    endtask

    task automatic modelStep();
        byte lamp, nm;
        bit chk, changed, prevLit, curLit, l2l, trk, ok;
        longint d, lo;
        int code;
        if (!rst_n) begin
            modelReset();
            return;
        end
        lamp    = lampOf(red, yellow, green);
        chk     = !maintenance && (mMode != "m");
        changed = (lamp != mPrev);
        prevLit = isLit(mPrev);
        curLit  = isLit(lamp);
        l2l     = changed && prevLit && curLit;
        trk     = (mMode == "s") || (mMode == "t");
        ok      = prevLit && curLit && (ordPos(lamp) == (ordPos(mPrev) + 1) % 3);
        d       = durOf(mPrev);
        lo      = (d - TOL < 0) ? 0 : d - TOL;
        code    = 0;
        if (chk) begin
            if (lamp == "M") code = 1;
            else if (trk && prevLit && lamp == "O") code = 2;
            else if (trk && l2l && !ok) code = 3;
            else if (mMode == "t" && l2l && d != 0 && mCnt < lo) code = 4;
            else if (mMode == "t" && prevLit && !changed && d != 0 && mCnt > d + TOL && !mLongDone) code = 5;
        end
        mPhaseValid = chk && trk && l2l;
        if (mPhaseValid) mPhaseLen = mCnt;
        if (code != 0) begin
            if (!mFault || clear_fault) mCode = code;
            mFault = 1;
            if (mFcount < (1 << FCNT_W) - 1) mFcount++;
        end else if (clear_fault) begin
            mFault = 0;
            mCode  = 0;
        end
        if (chk && mMode == "t" && mPrev == "Y" && lamp == "R" && code == 0)
            mCycles = (mCycles + 1) & CNT_MAX;
        nm = mMode;
        if (maintenance) nm = "m";
        else case (mMode)
            "o": if (curLit) nm = "s";
            "s": begin
                if (lamp == "O") nm = "o";
                else if (l2l && ok) nm = "t";
            end
            "t": begin
                if (lamp == "O") nm = "o";
                else if (lamp == "M") nm = "s";
                else if (l2l && !ok) nm = "s";
            end
            default: nm = (lamp == "O") ? "o" : "s";
        endcase
        if (maintenance || mMode == "m") begin
            mCnt = 0; mLongDone = 0;
        end else if (changed) begin
            mCnt = 1; mLongDone = 0;
        end else begin
            if (mCnt < CNT_MAX) mCnt++;
            if (code == 5) mLongDone = 1;
        end
        mPrev = lamp;
        mMode = nm;
    endtask

    task automatic applyStimulus(input byte lamp, input bit maint, input bit clr);
        red         = (lamp == "R") || (lamp == "M");
        yellow      = (lamp == "Y") || (lamp == "M");
        green       = (lamp == "G");
        maintenance = maint;
        clear_fault = clr;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic hold(input byte lamp, input int n);
        for (int i = 0; i < n; i++) applyStimulus(lamp, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        applyStimulus("O", 1'b0, 1'b0);
        applyStimulus("R", 1'b0, 1'b0);
        checks++; if (fault !== 1'b0) $display("[TB] FAIL reset_fault: got %0b want 0", fault); else passed++;
        checks++; if (fault_code !== 3'd0) $display("[TB] FAIL reset_code: got %0d want 0", fault_code); else passed++;
        checks++; if (fault_count !== '0) $display("[TB] FAIL reset_count: got %0d want 0", fault_count); else passed++;
        checks++; if (cycle_count !== '0) $display("[TB] FAIL reset_cycles: got %0d want 0", cycle_count); else passed++;
        checks++; if (phase_valid !== 1'b0) $display("[TB] FAIL reset_pv: got %0b want 0", phase_valid); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_nominal();
        hold("R", 10);
        applyStimulus("G", 1'b0, 1'b0);
        checks++; if (phase_valid !== 1'b1 || phase_len !== 32'd10) $display("[TB] FAIL nom_red_len: got v=%0b len=%0d want v=1 len=10", phase_valid, phase_len); else passed++;
        hold("G", 6);
        checks++; if (phase_valid !== 1'b0) $display("[TB] FAIL nom_pulse_width: got %0b want 0", phase_valid); else passed++;
        applyStimulus("Y", 1'b0, 1'b0);
        checks++; if (phase_valid !== 1'b1 || phase_len !== 32'd7) $display("[TB] FAIL nom_green_len: got v=%0b len=%0d want v=1 len=7", phase_valid, phase_len); else passed++;
        hold("Y", 2);
        applyStimulus("R", 1'b0, 1'b0);
        checks++; if (phase_len !== 32'd3 || cycle_count !== 32'd1) $display("[TB] FAIL nom_cycle1: got len=%0d cyc=%0d want len=3 cyc=1", phase_len, cycle_count); else passed++;
        hold("R", 9); applyStimulus("G", 1'b0, 1'b0);
        hold("G", 6); applyStimulus("Y", 1'b0, 1'b0);
        hold("Y", 2); applyStimulus("R", 1'b0, 1'b0);
        checks++; if (cycle_count !== 32'd2) $display("[TB] FAIL nom_cycle2: got %0d want 2", cycle_count); else passed++;
        checks++; if (fault !== 1'b0 || fault_count !== '0) $display("[TB] FAIL nom_no_fault: got f=%0b cnt=%0d want 0 0", fault, fault_count); else passed++;
    endtask

    task automatic test_short();
        hold("R", 9);
        applyStimulus("G", 1'b0, 1'b0);
        hold("G", 4);
        checks++; if (fault !== 1'b0) $display("[TB] FAIL short_early: got %0b want 0", fault); else passed++;
        applyStimulus("Y", 1'b0, 1'b0);
        checks++; if (fault !== 1'b1 || fault_code !== 3'd4 || fault_count !== 8'd1) $display("[TB] FAIL short_fault: got f=%0b code=%0d cnt=%0d want 1 4 1", fault, fault_code, fault_count); else passed++;
        hold("Y", 2);
    endtask

    task automatic test_long();
        applyStimulus("R", 1'b0, 1'b1);
        checks++; if (fault !== 1'b0 || fault_count !== 8'd1) $display("[TB] FAIL long_clear: got f=%0b cnt=%0d want 0 1", fault, fault_count); else passed++;
        hold("R", 11);
        checks++; if (fault !== 1'b0) $display("[TB] FAIL long_early: got %0b want 0", fault); else passed++;
        hold("R", 1);
        checks++; if (fault !== 1'b1 || fault_code !== 3'd5 || fault_count !== 8'd2) $display("[TB] FAIL long_fault: got f=%0b code=%0d cnt=%0d want 1 5 2", fault, fault_code, fault_count); else passed++;
        hold("R", 3);
        applyStimulus("G", 1'b0, 1'b0);
        checks++; if (fault_count !== 8'd2) $display("[TB] FAIL long_once: got %0d want 2", fault_count); else passed++;
    endtask

    task automatic test_multi();
        applyStimulus("G", 1'b0, 1'b1);
        applyStimulus("M", 1'b0, 1'b0);
        checks++; if (fault !== 1'b1 || fault_code !== 3'd1 || fault_count !== 8'd3) $display("[TB] FAIL multi_fault: got f=%0b code=%0d cnt=%0d want 1 1 3", fault, fault_code, fault_count); else passed++;
        applyStimulus("G", 1'b0, 1'b0);
        applyStimulus("G", 1'b0, 1'b1);
        applyStimulus("G", 1'b1, 1'b0);
        applyStimulus("M", 1'b1, 1'b0);
        applyStimulus("G", 1'b1, 1'b0);
        applyStimulus("G", 1'b0, 1'b0);
        checks++; if (fault !== 1'b0 || fault_count !== 8'd3) $display("[TB] FAIL multi_maint: got f=%0b cnt=%0d want 0 3", fault, fault_count); else passed++;
        applyStimulus("G", 1'b0, 1'b0);
        applyStimulus("Y", 1'b0, 1'b0);
        checks++; if (fault !== 1'b0 || phase_valid !== 1'b1) $display("[TB] FAIL multi_sync_after_maint: got f=%0b v=%0b want 0 1", fault, phase_valid); else passed++;
        checks++; if (phase_len !== WIDTH'(mPhaseLen)) $display("[TB] FAIL multi_sync_len: got %0d want %0d", phase_len, mPhaseLen); else passed++;
    endtask

    task automatic test_illegal();
        hold("Y", 2);
        applyStimulus("R", 1'b0, 1'b0);
        hold("R", 2);
        applyStimulus("Y", 1'b0, 1'b0);
        checks++; if (fault !== 1'b1 || fault_code !== 3'd3 || fault_count !== 8'd4) $display("[TB] FAIL illegal_fault: got f=%0b code=%0d cnt=%0d want 1 3 4", fault, fault_code, fault_count); else passed++;
        applyStimulus("Y", 1'b0, 1'b1);
        checks++; if (fault !== 1'b0 || fault_code !== 3'd0 || fault_count !== 8'd4) $display("[TB] FAIL clear_fault: got f=%0b code=%0d cnt=%0d want 0 0 4", fault, fault_code, fault_count); else passed++;
        applyStimulus("G", 1'b0, 1'b0);
        checks++; if (fault !== 1'b1 || fault_code !== 3'd3) $display("[TB] FAIL illegal_sync: got f=%0b code=%0d want 1 3", fault, fault_code); else passed++;
        applyStimulus("O", 1'b0, 1'b1);
        checks++; if (fault !== 1'b1 || fault_code !== 3'd2 || fault_count !== 8'd6) $display("[TB] FAIL dark_with_clear: got f=%0b code=%0d cnt=%0d want 1 2 6", fault, fault_code, fault_count); else passed++;
    endtask

    task automatic test_reset_mid();
        hold("R", 10);
        applyStimulus("G", 1'b0, 1'b0);
        hold("G", 2);
        rst_n = 1'b0;
        #1;
        modelReset();
        checks++; if (fault !== 1'b0 || fault_code !== 3'd0 || fault_count !== '0) $display("[TB] FAIL rst_async_fault: got f=%0b code=%0d cnt=%0d want 0 0 0", fault, fault_code, fault_count); else passed++;
        checks++; if (cycle_count !== '0 || phase_len !== '0 || phase_valid !== 1'b0) $display("[TB] FAIL rst_async_stats: got cyc=%0d len=%0d v=%0b want 0 0 0", cycle_count, phase_len, phase_valid); else passed++;
        hold("G", 3);
        red = 1'b1; green = 1'b0;
        rst_n = 1'b1;
        hold("R", 4);
        applyStimulus("G", 1'b0, 1'b0);
        checks++; if (fault !== 1'b0 || phase_valid !== 1'b1 || phase_len !== 32'd4) $display("[TB] FAIL rst_first_phase: got f=%0b v=%0b len=%0d want 0 1 4", fault, phase_valid, phase_len); else passed++;
        hold("G", 2);
        applyStimulus("Y", 1'b0, 1'b0);
        checks++; if (fault !== 1'b1 || fault_code !== 3'd4) $display("[TB] FAIL rst_next_checked: got f=%0b code=%0d want 1 4", fault, fault_code); else passed++;
    endtask

    task automatic test_random();
        byte cur, nxt;
        int remain, maintLeft, r;
        longint d;
        bit m, clr;
        cur = "R"; remain = 0; maintLeft = 0;
        for (int i = 0; i < 1500; i++) begin
            if (remain == 0) begin
                r = $urandom_range(0, 99);
                if (isLit(cur)) begin
                    if (r < 80)      nxt = lampAt(ordPos(cur) + 1);
                    else if (r < 88) nxt = lampAt(ordPos(cur) + 2);
                    else if (r < 94) nxt = "O";
                    else             nxt = "M";
                end else begin
                    nxt = lampAt($urandom_range(0, 2));
                end
                cur = nxt;
                if (cur == "M") remain = 1;
                else if (cur == "O") remain = $urandom_range(1, 3);
                else begin
                    d = durOf(cur);
                    remain = (d == 0) ? $urandom_range(1, 6) : int'(d) - 2 + $urandom_range(0, 4);
                    if (remain < 1) remain = 1;
                end
            end
            m = 1'b0;
            if (maintLeft > 0) begin
                maintLeft--; m = 1'b1;
            end else if ($urandom_range(0, 99) < 2) begin
                maintLeft = $urandom_range(1, 5);
            end
            clr = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 99) < 3) begin
                case ($urandom_range(0, 2))
                    0:       red_duration    = WIDTH'($urandom_range(0, 6));
                    1:       yellow_duration = WIDTH'($urandom_range(0, 6));
                    default: green_duration  = WIDTH'($urandom_range(0, 6));
                endcase
            end
            applyStimulus(cur, m, clr);
            remain--;
            checks++; if (fault !== mFault) $display("[TB] FAIL rnd_fault cyc %0d: got %0b want %0b", i, fault, mFault); else passed++;
            checks++; if (fault_code !== 3'(mCode)) $display("[TB] FAIL rnd_code cyc %0d: got %0d want %0d", i, fault_code, mCode); else passed++;
            checks++; if (fault_count !== FCNT_W'(mFcount)) $display("[TB] FAIL rnd_count cyc %0d: got %0d want %0d", i, fault_count, mFcount); else passed++;
            checks++; if (cycle_count !== WIDTH'(mCycles)) $display("[TB] FAIL rnd_cycles cyc %0d: got %0d want %0d", i, cycle_count, mCycles); else passed++;
            checks++; if (phase_len !== WIDTH'(mPhaseLen)) $display("[TB] FAIL rnd_len cyc %0d: got %0d want %0d", i, phase_len, mPhaseLen); else passed++;
            checks++; if (phase_valid !== mPhaseValid) $display("[TB] FAIL rnd_valid cyc %0d: got %0b want %0b", i, phase_valid, mPhaseValid); else passed++;
        end
    endtask

    initial begin
        modelReset();
        $display("[TB] start");
        test_reset();
        test_nominal();
        test_short();
        test_long();
        test_multi();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/semaforo_monitor.md
Name: semaforo_monitor

Overview:
Downstream checker for the traffic-light controller (`semaforo`). It samples the controller's red/yellow/green outputs and the same programmed durations. It verifies one-hot lamp drive, the legal phase order RED->GREEN->YELLOW->RED and per-phase dwell time against the programmed durations. It reports a sticky fault with a code, a saturating fault counter, completed-cycle statistics and the last measured phase length, for use by supervisory logic.

Parameters:
WIDTH, 32, width of the duration inputs, phase counter and cycle_count.
TOL, 1, allowed +/- deviation in cycles between measured and programmed phase length.
FCNT_W, 8, width of the saturating fault_count.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
maintenance  input  1  controller in manual mode; all checks suspended while high.
red  input  1  red lamp from controller.
yellow  input  1  yellow lamp from controller.
green  input  1  green lamp from controller.
red_duration  input  WIDTH  programmed red length in cycles; 0 disables the red length check.
yellow_duration  input  WIDTH  programmed yellow length in cycles; 0 disables the yellow length check.
green_duration  input  WIDTH  programmed green length in cycles; 0 disables the green length check.
clear_fault  input  1  synchronous clear of fault/fault_code.
fault  output  1  sticky fault flag.
fault_code  output  3  code of first fault since last clear.
fault_count  output  FCNT_W  saturating count of fault events, cleared only by reset.
cycle_count  output  WIDTH  completed, fully-checked RED->GREEN->YELLOW cycles; wraps.
phase_len  output  WIDTH  length of last completed phase.
phase_valid  output  1  one-cycle pulse when phase_len updates.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state OFF; internal counter and previous-lamp register 0. Takes effect mid-phase immediately. After release, the first phase is never length-checked.
- Lamp decode: lamp = OFF (none lit), RED, YELLOW, GREEN, or MULTI (more than one lit). It is registered each cycle as prev_lamp.
- Phase counter cnt:
  - Loads 1 on the first cycle of a new lamp value.
  - Increments while the lamp is unchanged.
  - Saturates at all-ones.
- States:
  - OFF: lamp OFF and maintenance=0. Any single lamp -> SYNC.
  - SYNC: a partial phase with unknown start. On the first legal transition -> TRACK. No length checks; order, MULTI and DARK checks are still active.
  - TRACK: full checks.
  - MAINT: entered from any state when maintenance=1. No checks; cnt held at 0. On maintenance falling -> OFF if lamp OFF, else SYNC.
- Fault codes: 0 NONE, 1 MULTI, 2 DARK, 3 ILLEGAL_SEQ, 4 SHORT, 5 LONG.
  - MULTI: lamp MULTI outside MAINT.
  - DARK: lamp goes OFF from a lit lamp in SYNC/TRACK. The state then becomes OFF.
  - ILLEGAL_SEQ: a transition between lit lamps not in the legal order. The state then becomes SYNC.
  - SHORT: in TRACK, the phase ends with cnt < dur-TOL. Compute at WIDTH+1 bits; lower bound clamps at 0.
  - LONG: in TRACK, cnt > dur+TOL while the lamp is still lit. Flags once per phase, on the cycle cnt first exceeds the bound.
- Priority when several faults occur in the same cycle: MULTI > DARK > ILLEGAL_SEQ > SHORT > LONG. Only one event is counted.
- Fault outputs:
  - All registered; they assert the cycle after the violating sample.
  - fault_code latches only when fault=0, so the first fault is retained.
  - fault_count increments per event and saturates.
  - If clear_fault and a new event occur in the same cycle, the new event wins: fault=1 with the new code.
- Phase reporting: on every lit->lit transition in SYNC/TRACK, phase_len<=cnt and phase_valid=1 the next cycle. A YELLOW->RED transition in TRACK with no fault in that cycle increments cycle_count.
- Duration inputs are sampled at phase end (SHORT) and continuously (LONG); changes mid-phase apply immediately.

Decomposition:
- Package semaforo_pkg:
  - lamp_e enum (OFF, RED, YELLOW, GREEN, MULTI).
  - mon_state_e (OFF, SYNC, TRACK, MAINT).
  - fault_e codes.
  - next_legal() function.
- One sub-module, semaforo_phase_timer: holds the cnt counter with load/saturate and the SHORT/LONG compare against the duration, parameterised by WIDTH and TOL.

Test Plan:
- Nominal run (red 10, green 7, yellow 3, TOL=1): start red, then two full cycles -> no fault. cycle_count=1 after the first checked yellow->red, then 2. phase_valid pulses carry 10, 7, 3.
- Green held 5 cycles then yellow -> fault=1, fault_code=4 one cycle after the transition; fault_count=1.
- Red held 13 cycles in TRACK -> fault_code=5 asserted the cycle after cnt reaches 12; only one event counted for that phase.
- red and yellow both high for 1 cycle with maintenance=0 -> fault_code=1. The same stimulus with maintenance=1 -> no fault, and the state is SYNC after maintenance drops.
- Red->yellow transition -> fault_code=3. Pulse clear_fault -> fault=0, fault_count unchanged. clear_fault coincident with a new DARK event -> fault=1, code 2.
- rst_n low for 3 cycles mid-green -> all outputs 0 immediately. After release, the first red of 4 cycles raises no SHORT; the next phase is checked.
